// File: rtl/gpo_event_scheduler.sv
// rtl/gpo_event_scheduler.sv - timestamped GPO event queue with free-running time counter
module gpo_event_scheduler #(
  parameter int FIFO_DEPTH = 16,
  parameter int TS_WIDTH   = 64
) (
  input  logic                             CLK100MHZ,
  input  logic                             reset,
  input  logic                             counter_run,
  input  logic                             counter_clear,
  input  logic                             wr_en,
  input  logic [TS_WIDTH+63:0]             wr_data,
  input  logic                             flush,
  input  logic                             error_clear,
  output logic                             full,
  output logic                             empty,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
  output logic [TS_WIDTH-1:0]              current_time,
  output logic                             counter_matched,
  output logic [TS_WIDTH+63:0]             event_data,
  output logic                             late_error,
  output logic                             overflow_error,
  output logic [TS_WIDTH+63:0]             error_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = TS_WIDTH + 64;

  typedef enum logic [1:0] {IDLE, LOAD, ARMED} state_t;

  state_t               state, state_nx;
  logic [TS_WIDTH-1:0]  time_q;
  logic [ENT_W-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [ENT_W-1:0]     head;
  logic [TS_WIDTH-1:0]  head_ts;

  logic push_ok, push_drop, pop, more, fire, late;

  assign full         = (count == CNT_W'(FIFO_DEPTH));
  assign empty        = (count == '0);
  assign fifo_count   = count;
  assign current_time = time_q;
  assign head_ts      = head[ENT_W-1:64];

  // full is sampled at cycle start, so a push into a full FIFO is dropped even if a pop happens now;
  // a push coinciding with flush is silently discarded
  assign push_ok   = wr_en & ~full & ~flush;
  assign push_drop = wr_en &  full & ~flush;
  assign pop       = (state == LOAD) & ~empty & ~flush;
  // an entry arriving this cycle counts as pending so the head can be loaded without an idle bubble
  assign more      = ~empty | push_ok;

  // timestamp counter: clear has priority over run, natural 2^64 wrap
  always_ff @(posedge CLK100MHZ) begin
    if (reset || counter_clear) time_q <= '0;
    else if (counter_run)       time_q <= time_q + 1'b1;
  end

  // FIFO storage array; contents need no reset because pointers and count define validity
  always_ff @(posedge CLK100MHZ) begin
    if (push_ok) fifo_mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK100MHZ) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // scheduler state register
  always_ff @(posedge CLK100MHZ) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next state and fire/late decisions; flush forces IDLE and suppresses both outcomes
  always_comb begin
    state_nx = state;
    fire     = 1'b0;
    late     = 1'b0;
    case (state)
      IDLE:  if (more) state_nx = LOAD;
      LOAD:  state_nx = empty ? IDLE : ARMED;
      ARMED: begin
        if (head_ts == time_q) begin
          fire     = 1'b1;
          state_nx = more ? LOAD : IDLE;
        end else if (head_ts < time_q) begin
          late     = 1'b1;
          state_nx = more ? LOAD : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (flush) begin
      state_nx = IDLE;
      fire     = 1'b0;
      late     = 1'b0;
    end
  end

  // head register holds the entry currently waiting for its timestamp
  always_ff @(posedge CLK100MHZ) begin
    if (reset || flush) head <= '0;
    else if (pop)       head <= fifo_mem[rd_ptr];
  end

  // fire strobe and fired entry; event_data holds its last value between fires
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      counter_matched <= 1'b0;
      event_data      <= '0;
    end else begin
      counter_matched <= fire;
      if (fire) event_data <= head;
    end
  end

  // sticky error flags; a new error in the same cycle as error_clear keeps the flag set
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      late_error     <= 1'b0;
      overflow_error <= 1'b0;
      error_data     <= '0;
    end else begin
      late_error     <= late      | (late_error     & ~error_clear);
      overflow_error <= push_drop | (overflow_error & ~error_clear);
      if (push_drop) error_data <= wr_data;
      else if (late) error_data <= head;
    end
  end

endmodule
